// File: rtl/aes_decrypt_top_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_decrypt_top_if                                            |
// | Brief    : Start/data/key request and plaintext/valid/busy response bus  |
// |            of the iterative AES-128 inverse cipher.                      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface aes_decrypt_top_if;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic [127:0] AES_data_out;
    logic         AES_data_out_valid;
    logic         AES_busy;

    modport master (
        output AES_en, AES_data_in, AES_key_in,
        input  AES_data_out, AES_data_out_valid, AES_busy
    );

    modport slave (
        input  AES_en, AES_data_in, AES_key_in,
        output AES_data_out, AES_data_out_valid, AES_busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_decrypt_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : aes_decrypt_top                                               |
// | Brief    : Iterative AES-128 inverse cipher, one round per clock after   |
// |            a forward key expansion; result 21 clocks after accept.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module aes_decrypt_top #(
    parameter int NR       = 10,
    parameter int KEXP_CYC = 10
) (
    input  logic             AES_clk,
    input  logic             AES_rst,
    aes_decrypt_top_if.slave bus
);

    localparam logic [7:0] c_RCON_INIT = 8'h01;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEXP  = 3'd1,
        S_ARK10 = 3'd2,
        S_ROUND = 3'd3,
        S_LAST  = 3'd4
    } state_t;

    function automatic logic [7:0] f_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Division by x modulo 0x11b: fold the polynomial back in when the LSB is set.
    function automatic logic [7:0] f_inv_xtime(input logic [7:0] b);
        return b[0] ? {1'b1, b[7:1] ^ 7'h0d} : {1'b0, b[7:1]};
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] t;
        r = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ t;
            t = f_xtime(t);
        end
        return r;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] f_ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = f_gmul(p, p);
            r = f_gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] f_rotl(input logic [7:0] b, input int k);
        logic [15:0] t;
        t = {b, b} << k;
        return t[15:8];
    endfunction

    function automatic logic [7:0] f_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = f_ginv(a);
        return b ^ f_rotl(b, 1) ^ f_rotl(b, 2) ^ f_rotl(b, 3) ^ f_rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] f_inv_sbox(input logic [7:0] a);
        return f_ginv(f_rotl(a, 1) ^ f_rotl(a, 3) ^ f_rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] f_sub_rot(input logic [31:0] w);
        return {f_sbox(w[23:16]), f_sbox(w[15:8]), f_sbox(w[7:0]), f_sbox(w[31:24])};
    endfunction

    // Byte n sits at row n%4, column n/4; row r rotates right by r columns.
    function automatic logic [127:0] f_inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        int           src;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            src = ((((n / 4) - (n % 4)) + 4) % 4) * 4 + (n % 4);
            o[127 - 8*n -: 8] = f_inv_sbox(s[127 - 8*src -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] f_inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) a[i] = s[127 - 8*(4*c + i) -: 8];
            for (int i = 0; i < 4; i++) begin
                o[127 - 8*(4*c + i) -: 8] = f_gmul(a[i], 8'h0e) ^ f_gmul(a[(i+1)%4], 8'h0b)
                                          ^ f_gmul(a[(i+2)%4], 8'h0d) ^ f_gmul(a[(i+3)%4], 8'h09);
            end
        end
        return o;
    endfunction

    state_t         r_state;
    state_t         w_state_next;
    logic           w_accept;
    logic           r_en_d;
    logic [3:0]     r_cnt;
    logic [7:0]     r_rcon;
    logic [127:0]   r_st;
    logic [127:0]   r_rk;
    logic [127:0]   r_out;
    logic           r_valid;
    logic           r_busy;

    logic           w_kexp_done;
    logic           w_round_done;
    logic [31:0]    w_w3_src;
    logic [31:0]    w_sw;
    logic [31:0]    w_w0n;
    logic [31:0]    w_w1n;
    logic [31:0]    w_w2n;
    logic [127:0]   w_rk_next;
    logic [127:0]   w_rk_prev;
    logic [127:0]   w_isb;

    assign w_kexp_done  = (r_cnt == 4'(KEXP_CYC - 1));
    assign w_round_done = (r_cnt == 4'(NR - 2));

    // One shared set of forward S-boxes: going forward it sees w3 directly,
    // going backward it sees w3 rebuilt from w3' ^ w2'.
    assign w_w3_src  = (r_state == S_KEXP) ? r_rk[31:0] : (r_rk[31:0] ^ r_rk[63:32]);
    assign w_sw      = f_sub_rot(w_w3_src) ^ {r_rcon, 24'h000000};

    assign w_w0n     = r_rk[127:96] ^ w_sw;
    assign w_w1n     = r_rk[95:64]  ^ w_w0n;
    assign w_w2n     = r_rk[63:32]  ^ w_w1n;
    assign w_rk_next = {w_w0n, w_w1n, w_w2n, r_rk[31:0] ^ w_w2n};
    assign w_rk_prev = {r_rk[127:96] ^ w_sw, r_rk[95:64] ^ r_rk[127:96],
                        r_rk[63:32] ^ r_rk[95:64], r_rk[31:0] ^ r_rk[63:32]};

    assign w_isb     = f_inv_shift_sub(r_st);

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.AES_en && !r_en_d) begin
                    w_accept     = 1'b1;
                    w_state_next = S_KEXP;
                end
            end
            S_KEXP:  if (w_kexp_done) w_state_next = S_ARK10;
            S_ARK10: w_state_next = S_ROUND;
            S_ROUND: if (w_round_done) w_state_next = S_LAST;
            S_LAST:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            r_en_d  <= 1'b0;
            r_cnt   <= 4'd0;
            r_rcon  <= 8'h00;
            r_st    <= '0;
            r_rk    <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_en_d  <= bus.AES_en;
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_st   <= bus.AES_data_in;
                        r_rk   <= bus.AES_key_in;
                        r_rcon <= c_RCON_INIT;
                        r_cnt  <= 4'd0;
                        r_busy <= 1'b1;
                    end
                end
                S_KEXP: begin
                    r_rk <= w_rk_next;
                    // rcon stays at its last forward value so the backward walk starts there.
                    if (w_kexp_done) begin
                        r_cnt <= 4'd0;
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                        r_rcon <= f_xtime(r_rcon);
                    end
                end
                S_ARK10: begin
                    r_st   <= r_st ^ r_rk;
                    r_rk   <= w_rk_prev;
                    r_rcon <= f_inv_xtime(r_rcon);
                end
                S_ROUND: begin
                    r_st   <= f_inv_mix(w_isb ^ r_rk);
                    r_rk   <= w_rk_prev;
                    r_rcon <= f_inv_xtime(r_rcon);
                    r_cnt  <= r_cnt + 4'd1;
                end
                S_LAST: begin
                    r_out   <= w_isb ^ r_rk;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.AES_data_out       = r_out;
    assign bus.AES_data_out_valid = r_valid;
    assign bus.AES_busy           = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_aes_decrypt_top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_aes_decrypt_top                                            |
// | Brief    : Bench for aes_decrypt_top against a forward-cipher model.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_aes_decrypt_top;

    localparam logic [127:0] c_KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_PT_C  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         chk_en = 1'b0;
    logic [127:0] drv_exp = '0;
    int           n_vec = 0;
    int           n_err = 0;
    int           n_valid = 0;
    int           cyc = 0;
    int           last_v = 0;
    int           prev_v = 0;
    logic [7:0]   sbox [256];

    aes_decrypt_top_if bus ();

    aes_decrypt_top dut (
        .AES_clk (clk),
        .AES_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Walk the multiplicative group by generator 3 while tracking its inverse.
    task automatic build_sbox;
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[8'h00] = 8'h63;
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, x, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) w[i] = key[127 - 8*i -: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1) + j];
            if (i % 4 == 0) begin
                x      = tmp[0];
                tmp[0] = sbox[tmp[1]] ^ rc;
                tmp[1] = sbox[tmp[2]];
                tmp[2] = sbox[tmp[3]];
                tmp[3] = sbox[x];
                rc     = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)]];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r + i];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // Expected bus behaviour: accept on a rising en while idle, result 21 edges later.
    logic         m_busy, m_valid, m_en_prev;
    logic [127:0] m_out, m_pending;
    int           m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy    <= 1'b0;
            m_valid   <= 1'b0;
            m_en_prev <= 1'b0;
            m_out     <= '0;
            m_pending <= '0;
            m_cnt     <= 0;
        end else begin
            m_en_prev <= bus.AES_en;
            m_valid   <= 1'b0;
            if (!m_busy) begin
                if (bus.AES_en && !m_en_prev) begin
                    m_busy    <= 1'b1;
                    m_cnt     <= 1;
                    m_pending <= drv_exp;
                end
            end else if (m_cnt == 21) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_out   <= m_pending;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    initial begin
        wait (chk_en);
        forever begin
            @(negedge clk);
            check("valid", {127'd0, bus.AES_data_out_valid}, {127'd0, m_valid});
            check("busy", {127'd0, bus.AES_busy}, {127'd0, m_busy});
            check("data_out", bus.AES_data_out, m_out);
            if (bus.AES_data_out_valid) begin
                n_valid++;
                prev_v = last_v;
                last_v = cyc;
            end
        end
    end

    task automatic pulse_start(input logic [127:0] k, input logic [127:0] ct,
                               input logic [127:0] pt, input int hold);
        @(posedge clk);
        #1;
        bus.AES_key_in  = k;
        bus.AES_data_in = ct;
        drv_exp         = pt;
        bus.AES_en      = 1'b1;
        repeat (hold) @(posedge clk);
        #1 bus.AES_en = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int lat);
        lat = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.AES_data_out_valid) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL valid_timeout: got no valid within %0d cycles, expected a pulse", bound);
        end
    endtask

    initial begin
        int           lat;
        int           v0;
        logic [127:0] k, p;
        bus.AES_en      = 1'b0;
        bus.AES_data_in = '0;
        bus.AES_key_in  = '0;

        build_sbox();
        check("model_sbox_00", {120'd0, sbox[8'h00]}, 128'h63);
        check("model_sbox_01", {120'd0, sbox[8'h01]}, 128'h7c);
        check("model_sbox_53", {120'd0, sbox[8'h53]}, 128'hed);
        check("model_fips_b", aes_enc(c_KEY_B, c_PT_B), c_CT_B);
        check("model_fips_c1", aes_enc(c_KEY_C, c_PT_C), c_CT_C);

        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // FIPS-197 B with latency
        pulse_start(c_KEY_B, c_CT_B, c_PT_B, 1);
        wait_valid(40, lat);
        check("fips_b_latency", 128'(lat), 128'd21);
        check("fips_b_data", bus.AES_data_out, c_PT_B);

        // FIPS-197 C.1
        pulse_start(c_KEY_C, c_CT_C, c_PT_C, 1);
        wait_valid(40, lat);
        check("fips_c1_data", bus.AES_data_out, c_PT_C);

        // en held high, inputs changed mid-flight
        #1 v0 = n_valid;
        @(posedge clk);
        #1;
        bus.AES_key_in  = c_KEY_B;
        bus.AES_data_in = c_CT_B;
        drv_exp         = c_PT_B;
        bus.AES_en      = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.AES_key_in  = c_KEY_C;
        bus.AES_data_in = c_CT_C;
        drv_exp         = c_PT_C;
        repeat (55) @(posedge clk);
        #1 bus.AES_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_en_pulses", 128'(n_valid - v0), 128'd1);
        check("hold_en_data", bus.AES_data_out, c_PT_B);

        // reset mid-operation, then a clean restart
        pulse_start(c_KEY_B, c_CT_B, c_PT_B, 1);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", {127'd0, bus.AES_busy}, 128'd0);
        check("rst_data", bus.AES_data_out, 128'd0);
        v0 = n_valid;
        repeat (30) @(posedge clk);
        #1 check("rst_no_valid", 128'(n_valid - v0), 128'd0);
        pulse_start(c_KEY_B, c_CT_B, c_PT_B, 1);
        wait_valid(40, lat);
        check("rst_restart_data", bus.AES_data_out, c_PT_B);

        // back-to-back: second accept on the edge right after valid
        pulse_start(c_KEY_C, c_CT_C, c_PT_C, 1);
        wait_valid(40, lat);
        check("b2b_first_data", bus.AES_data_out, c_PT_C);
        bus.AES_key_in  = c_KEY_B;
        bus.AES_data_in = c_CT_B;
        drv_exp         = c_PT_B;
        bus.AES_en      = 1'b1;
        @(posedge clk);
        #1 bus.AES_en = 1'b0;
        wait_valid(40, lat);
        #1;
        check("b2b_second_data", bus.AES_data_out, c_PT_B);
        check("b2b_spacing", 128'(last_v - prev_v), 128'd22);

        // loopback of an encryption produced by the model
        p = 128'h00000081_00000000_00000000_00000000;
        k = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
        pulse_start(k, aes_enc(k, p), p, 1);
        wait_valid(40, lat);
        check("loopback_data", bus.AES_data_out, p);

        // random keys, plaintexts, en widths and gaps
        for (int n = 0; n < 10; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            repeat ($urandom_range(0, 4)) @(posedge clk);
            pulse_start(k, aes_enc(k, p), p, int'($urandom_range(1, 3)));
            wait_valid(40, lat);
            check("random_data", bus.AES_data_out, p);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
